// File: rtl/mem_dump_uart_if.sv
// Bundle of the dump request, port-B memory read path and UART status lines.
interface mem_dump_uart_if #(
  parameter int unsigned ADDR_W = 18,
  parameter int unsigned DATA_W = 24
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W-1:0] word_count;
  logic [ADDR_W-1:0] address_b;
  logic [DATA_W-1:0] read_data_b;
  logic              tx;
  logic              busy;
  logic              done;

  // Requester / memory side
  modport master (
    output start, base_addr, word_count, read_data_b,
    input  address_b, tx, busy, done
  );

  // Dump engine side
  modport slave (
    input  start, base_addr, word_count, read_data_b,
    output address_b, tx, busy, done
  );
endinterface

// File: rtl/mem_dump_uart.sv
// Streams a block of data memory out over UART TX (8N1), 3 bytes per word, MSB byte first.
// Reads through memory port B only, so dumps run alongside normal pipeline accesses on port A.
module mem_dump_uart #(
  parameter int unsigned ADDR_W       = 18,
  parameter int unsigned DATA_W       = 24,
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned RD_LAT       = 2
) (
  input  logic           clk,
  input  logic           rst,
  mem_dump_uart_if.slave bus
);

  localparam int unsigned CNT_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned WAIT_N = (RD_LAT > 1) ? RD_LAT - 1 : 1;
  localparam int unsigned WAIT_W = (WAIT_N > 1) ? $clog2(WAIT_N) : 1;

  localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_N - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_LOAD,
    S_SEND,
    S_NEXT,
    S_FIN
  } state_t;

  state_t             state;
  logic [ADDR_W-1:0]  cur_addr;
  logic [ADDR_W-1:0]  remaining;
  logic [ADDR_W-1:0]  address_b_r;
  logic [DATA_W-1:0]  shreg;
  logic [1:0]         byte_idx;
  logic [3:0]         bit_idx;
  logic [CNT_W-1:0]   clk_cnt;
  logic [WAIT_W-1:0]  wait_cnt;
  logic               tx_r;
  logic               busy_r;
  logic               done_r;
  logic [7:0]         cur_byte;

  assign cur_byte        = shreg[DATA_W-1 -: 8];
  assign bus.address_b   = address_b_r;
  assign bus.tx          = tx_r;
  assign bus.busy        = busy_r;
  assign bus.done        = done_r;

  // Dump sequencer: memory read, UART bit timing and status outputs, all registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cur_addr    <= '0;
      remaining   <= '0;
      address_b_r <= '0;
      shreg       <= '0;
      byte_idx    <= '0;
      bit_idx     <= '0;
      clk_cnt     <= '0;
      wait_cnt    <= '0;
      tx_r        <= 1'b1;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            cur_addr  <= bus.base_addr;
            remaining <= bus.word_count;
            if (bus.word_count == '0) begin
              state <= S_FIN;
            end else begin
              // Address is launched on entry so port B sees it in the first ISSUE cycle.
              state       <= S_ISSUE;
              busy_r      <= 1'b1;
              address_b_r <= bus.base_addr;
            end
          end
        end

        S_ISSUE: begin
          wait_cnt <= '0;
          state    <= (RD_LAT > 1) ? S_WAIT : S_LOAD;
        end

        S_WAIT: begin
          if (wait_cnt == WAIT_LAST) begin
            state <= S_LOAD;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        S_LOAD: begin
          shreg    <= bus.read_data_b;
          byte_idx <= '0;
          bit_idx  <= '0;
          clk_cnt  <= '0;
          tx_r     <= 1'b0;
          state    <= S_SEND;
        end

        S_SEND: begin
          if (clk_cnt == BIT_LAST) begin
            clk_cnt <= '0;
            if (bit_idx == 4'd9) begin
              if (byte_idx == 2'd2) begin
                tx_r  <= 1'b1;
                state <= S_NEXT;
              end else begin
                // Next byte's start bit follows the stop bit with no idle gap.
                byte_idx <= byte_idx + 1'b1;
                bit_idx  <= '0;
                shreg    <= {shreg[DATA_W-9:0], 8'h00};
                tx_r     <= 1'b0;
              end
            end else begin
              bit_idx <= bit_idx + 1'b1;
              tx_r    <= (bit_idx == 4'd8) ? 1'b1 : cur_byte[bit_idx[2:0]];
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end

        S_NEXT: begin
          remaining <= remaining - 1'b1;
          cur_addr  <= cur_addr + 1'b1;
          if (remaining == ADDR_W'(1)) begin
            // Pulse done while in FIN; the zero-length path arrives with done low instead.
            state  <= S_FIN;
            done_r <= 1'b1;
            busy_r <= 1'b0;
          end else begin
            state       <= S_ISSUE;
            address_b_r <= cur_addr + 1'b1;
          end
        end

        S_FIN: begin
          if (done_r) begin
            done_r <= 1'b0;
            state  <= S_IDLE;
          end else begin
            done_r <= 1'b1;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_dump_uart.sv
// Directed bench for mem_dump_uart with a 2-cycle behavioural port-B RAM and a UART line decoder.
module tb_mem_dump_uart;

  localparam int unsigned AW  = 18;
  localparam int unsigned DW  = 24;
  localparam int unsigned CPB = 4;

  logic clk = 1'b0;
  logic rst;

  mem_dump_uart_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_dump_uart #(
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .CLKS_PER_BIT(CPB),
    .RD_LAT      (2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Behavioural RAM: address -> data in 2 cycles
  logic [DW-1:0] mem [0:(2**AW)-1];
  logic [DW-1:0] r1, r2;
  always @(posedge clk) begin
    r1 <= mem[bus.address_b];
    r2 <= r1;
  end
  assign bus.read_data_b = r2;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  // Monitor state
  logic [7:0]    byte_q[$];
  int            gap_q[$];
  int            done_q[$];
  logic [AW-1:0] addr_q[$];
  logic [AW-1:0] last_addr = '0;
  logic [7:0]    rx_byte;
  bit            rx_active = 0;
  int            rx_cnt = 0;
  int            hi_run = 0;
  int            frame_err = 0;
  int            busy_cnt = 0;
  int            busy_fall = -1;
  int            first_low = -1;
  logic          prev_busy = 1'b0;
  int            t0 = 0;

  // Line decoder and event logger, sampled mid-cycle
  always @(negedge clk) begin
    if (rst) begin
      rx_active = 0;
      rx_cnt    = 0;
      hi_run    = 0;
    end else if (!rx_active) begin
      if (bus.tx === 1'b0) begin
        gap_q.push_back(hi_run);
        hi_run    = 0;
        rx_active = 1;
        rx_cnt    = 0;
        if (first_low < 0) first_low = cyc;
      end else begin
        hi_run++;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt == 2 && bus.tx !== 1'b0) frame_err++;
      if (rx_cnt >= 6 && rx_cnt <= 34 && (rx_cnt % 4) == 2) rx_byte[(rx_cnt - 6) / 4] = bus.tx;
      if (rx_cnt == 38) begin
        if (bus.tx !== 1'b1) frame_err++;
        byte_q.push_back(rx_byte);
      end
      if (rx_cnt == 39) rx_active = 0;
    end
    if (bus.done === 1'b1) done_q.push_back(cyc);
    if (bus.address_b !== last_addr) begin
      addr_q.push_back(bus.address_b);
      last_addr = bus.address_b;
    end
    if (bus.busy === 1'b1) busy_cnt++;
    if (prev_busy === 1'b1 && bus.busy === 1'b0) busy_fall = cyc;
    prev_busy = bus.busy;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_bytes(input string tag, input logic [7:0] e[$]);
    chk({tag, "_nbytes"}, byte_q.size(), e.size());
    for (int i = 0; i < e.size() && i < byte_q.size(); i++)
      chk($sformatf("%s_byte%0d", tag, i), {24'h0, byte_q[i]}, {24'h0, e[i]});
    chk({tag, "_frame_err"}, frame_err, 0);
  endtask

  task automatic chk_addrs(input string tag, input logic [AW-1:0] e[$]);
    chk({tag, "_naddr"}, addr_q.size(), e.size());
    for (int i = 0; i < e.size() && i < addr_q.size(); i++)
      chk($sformatf("%s_addr%0d", tag, i), {14'h0, addr_q[i]}, {14'h0, e[i]});
  endtask

  task automatic clear_logs();
    byte_q.delete();
    gap_q.delete();
    done_q.delete();
    addr_q.delete();
    busy_cnt  = 0;
    busy_fall = -1;
    first_low = -1;
    frame_err = 0;
  endtask

  // Start pulse sampled at "edge 0"; returns in cycle 1 with scratch values on base/count
  task automatic do_start(input logic [AW-1:0] base, input logic [AW-1:0] count);
    @(negedge clk);
    bus.start      = 1'b1;
    bus.base_addr  = base;
    bus.word_count = count;
    @(posedge clk);
    #1;
    t0             = cyc;
    bus.start      = 1'b0;
    bus.base_addr  = 18'h2AAAA;
    bus.word_count = 18'd7;
  endtask

  task automatic wait_done(input string tag, input int max_cyc);
    int n = 0;
    while (done_q.size() == 0 && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done_seen"}, (done_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
    repeat (8) @(negedge clk);
  endtask

  initial begin
    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.base_addr  = '0;
    bus.word_count = '0;
    mem[5]       = 24'hA1B2C3;
    mem[10]      = 24'h000001;
    mem[11]      = 24'h800000;
    mem[12]      = 24'hFFFFFF;
    mem[18'h3FFFF] = 24'h3C0FF0;
    mem[0]       = 24'h0F1E2D;
    mem[20]      = 24'h123456;
    mem[21]      = 24'hABCDEF;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", bus.tx, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_addr", bus.address_b, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // 1: single word
    clear_logs();
    do_start(18'd5, 18'd1);
    chk("t1_busy_c1", bus.busy, 1);
    chk("t1_addr_c1", bus.address_b, 5);
    wait_done("t1", 300);
    chk_bytes("t1", '{8'hA1, 8'hB2, 8'hC3});
    chk("t1_ndone", done_q.size(), 1);
    if (done_q.size() > 0) chk("t1_done_cyc", done_q[0] - t0 + 1, 125);
    chk("t1_busy_fall_cyc", busy_fall - t0 + 1, 125);
    chk("t1_tx_fall_cyc", first_low - t0 + 1, 4);

    // 2: three words, inter-word gap and address stepping
    clear_logs();
    do_start(18'd10, 18'd3);
    wait_done("t2", 600);
    chk_bytes("t2", '{8'h00, 8'h00, 8'h01, 8'h80, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF});
    chk("t2_ngap", gap_q.size(), 9);
    for (int j = 1; j < 9 && j < gap_q.size(); j++)
      chk($sformatf("t2_gap%0d", j), gap_q[j], ((j % 3) == 0) ? 4 : 0);
    chk_addrs("t2", '{18'd10, 18'd11, 18'd12});
    chk("t2_ndone", done_q.size(), 1);

    // 3: address wrap
    clear_logs();
    do_start(18'h3FFFF, 18'd2);
    wait_done("t3", 500);
    chk_bytes("t3", '{8'h3C, 8'h0F, 8'hF0, 8'h0F, 8'h1E, 8'h2D});
    chk_addrs("t3", '{18'h3FFFF, 18'h00000});

    // 4: zero-length dump
    clear_logs();
    do_start(18'd7, 18'd0);
    chk("t4_busy_c1", bus.busy, 0);
    wait_done("t4", 20);
    if (done_q.size() > 0) chk("t4_done_cyc", done_q[0] - t0 + 1, 2);
    chk("t4_ndone", done_q.size(), 1);
    chk("t4_busy_cycles", busy_cnt, 0);
    chk("t4_tx_low_seen", (first_low >= 0) ? 32'd1 : 32'd0, 32'd0);
    chk("t4_naddr", addr_q.size(), 0);

    // 5: start while busy is ignored
    clear_logs();
    do_start(18'd20, 18'd2);
    repeat (50) @(negedge clk);
    bus.start      = 1'b1;
    bus.base_addr  = 18'd10;
    bus.word_count = 18'd3;
    @(negedge clk);
    bus.start      = 1'b0;
    wait_done("t5", 500);
    repeat (20) @(negedge clk);
    chk_bytes("t5", '{8'h12, 8'h34, 8'h56, 8'hAB, 8'hCD, 8'hEF});
    chk_addrs("t5", '{18'd20, 18'd21});
    chk("t5_ndone", done_q.size(), 1);
    chk("t5_busy_after", bus.busy, 0);

    // 6: reset during data bit 3 of the second byte (cycles 60..63)
    clear_logs();
    do_start(18'd5, 18'd1);
    repeat (61) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("t6_rst_tx", bus.tx, 1);
    chk("t6_rst_busy", bus.busy, 0);
    chk("t6_rst_done", bus.done, 0);
    chk("t6_partial_nbytes", byte_q.size(), 1);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("t6_no_done", done_q.size(), 0);
    chk("t6_idle_tx", bus.tx, 1);
    clear_logs();
    do_start(18'd10, 18'd3);
    wait_done("t6b", 600);
    chk_bytes("t6b", '{8'h00, 8'h00, 8'h01, 8'h80, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF});
    chk("t6b_ndone", done_q.size(), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
